uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBIT, default 8: number of data bits per frame (5..9 supported).
REQ-002 Parameter SB_TICK, default 16: stop-bit duration in s_tick pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 s_tick  input  1  one-clk-wide oversampling strobe at 16x baud, from the baud timer's done output.
REQ-006 tx_start  input  1  request to send tx_din; sampled only in IDLE.
REQ-007 tx_din  input  DBIT  data word to transmit, LSB first.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 tx_busy  output  1  high in every state except IDLE.
REQ-010 tx_done_tick  output  1  one-clk pulse at the end of the stop bit.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, (PARITY when enabled), STOP; state, tick counter s_reg (4 bits), bit counter n_reg (ceil(log2 DBIT) bits), shift register b_reg (DBIT bits) and tx_reg SHALL all be registered.
REQ-012 tx SHALL be driven from tx_reg (registered, glitch-free), never from combinational logic.
REQ-013 IDLE: tx_reg=1; on a clk edge with tx_start=1, b_reg<=tx_din, s_reg<=0, state<=START; tx falls to 0 on that same edge.
REQ-014 IDLE SHALL ignore s_tick; tx_start and s_tick together in IDLE SHALL start the frame without counting that tick.
REQ-015 START: tx_reg=0; on each s_tick, s_reg increments; on the s_tick with s_reg==15, s_reg<=0, n_reg<=0, state<=DATA.
REQ-016 DATA: tx_reg=b_reg[0]; on the s_tick with s_reg==15, b_reg shifts right by one, s_reg<=0, n_reg increments; when n_reg==DBIT-1 at that tick, state<=STOP (or PARITY).
REQ-017 STOP: tx_reg=1; on the s_tick with s_reg==SB_TICK-1, state<=IDLE and tx_done_tick=1 for exactly that one clk; s_reg SHALL be wide enough for SB_TICK-1.
REQ-018 A frame SHALL last exactly 16*(1+DBIT)+SB_TICK s_tick pulses (+16 with parity); clk cycles without s_tick SHALL NOT advance any counter.
REQ-019 tx_start asserted while tx_busy=1 SHALL be ignored; no queueing; tx_din SHALL only be sampled in IDLE.
REQ-020 tx_start held high continuously SHALL produce back-to-back frames, with the next START entered on the clk after tx_done_tick.
REQ-021 tx_din changes after acceptance SHALL NOT affect the frame in progress.

Reset
REQ-022 On reset assertion, independent of clk: state=IDLE, s_reg=0, n_reg=0, b_reg=0, tx_reg=1, tx_busy=0, tx_done_tick=0.
REQ-023 Reset mid-frame SHALL abort the frame with tx high immediately; no tx_done_tick SHALL be issued for the aborted frame.
REQ-024 After reset deassertion, the first tx_start SHALL be accepted on the first clk edge.

Configuration
REQ-025 Macro UART_TX_PARITY_EN, when defined, SHALL add a PARITY state between DATA and STOP: tx_reg = XOR of the accepted word (even parity), held for 16 s_tick pulses.
REQ-026 The parity bit SHALL be computed from the word latched in IDLE, not from the shifting b_reg.
REQ-027 Without UART_TX_PARITY_EN, PARITY SHALL NOT exist and DATA SHALL proceed directly to STOP.

Verification
REQ-028 Reset then idle 100 clk with s_tick running -> tx=1, tx_busy=0, tx_done_tick never asserted.
REQ-029 DBIT=8, SB_TICK=16, s_tick every 4 clk, tx_din=0x55 with a one-clk tx_start -> tx bits 0,1,0,1,0,1,0,1,0,1 each 64 clk; tx_done_tick single pulse 160 ticks after start.
REQ-030 tx_din=0xA3 with a second tx_start pulse at tick 50 carrying 0xFF -> only 0xA3 framed; second request ignored; exactly one tx_done_tick.
REQ-031 tx_start held high, words 0x00 then 0xFF -> two contiguous frames; START of frame 2 one clk after the first tx_done_tick.
REQ-032 Reset asserted at tick 70 of a 0x0F frame -> tx=1 within the same cycle, tx_busy=0, no tx_done_tick; next 0x3C frame correct.
REQ-033 With UART_TX_PARITY_EN, tx_din=0x07 -> parity bit 1 after data; frame 176 ticks; tx_din=0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle between a UART transmitter and its client.
// The client holds the master modport and the transmitter holds the slave modport.
interface uart_tx_if #(
  parameter int unsigned DBIT = 8
);
  logic            s_tick;
  logic            tx_start;
  logic [DBIT-1:0] tx_din;
  logic            tx;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (
    output s_tick,
    output tx_start,
    output tx_din,
    input  tx,
    input  tx_busy,
    input  tx_done_tick
  );

  modport slave (
    input  s_tick,
    input  tx_start,
    input  tx_din,
    output tx,
    output tx_busy,
    output tx_done_tick
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter with 16x oversampling tick, DBIT data bits sent LSB first, and a SB_TICK-tick stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);

  localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
`ifdef UART_TX_PARITY_EN
  logic            par_reg, par_next;
`endif

  // State and datapath registers; outputs are registered from next-state values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      s_reg    <= '0;
      n_reg    <= '0;
      b_reg    <= '0;
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      s_reg    <= s_next;
      n_reg    <= n_next;
      b_reg    <= b_next;
      tx_reg   <= tx_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
`ifdef UART_TX_PARITY_EN
      par_reg  <= par_next;
`endif
    end
  end

  // Next-state logic; ticks are ignored in IDLE so a start coincident with a tick does not count it.
  always_comb begin
    state_next = state;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state)
      IDLE: begin
        if (bus.tx_start) begin
          b_next     = bus.tx_din;
          s_next     = '0;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          par_next   = ^bus.tx_din;
`endif
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_reg == SW'(15)) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_reg == SW'(15)) begin
            s_next = '0;
            b_next = b_reg >> 1;
            n_next = n_reg + NW'(1);
            if (n_reg == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bus.s_tick) begin
          if (s_reg == SW'(15)) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (bus.s_tick) begin
          if (s_reg == SW'(SB_TICK - 1)) begin
            s_next     = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line level follows the state being entered so tx changes on the same edge as the state.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign bus.tx           = tx_reg;
  assign bus.tx_busy      = busy_reg;
  assign bus.tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: every frame is compared tick-by-tick with an expected per-tick line-level list.
module tb_uart_tx;
  localparam int unsigned DBIT    = 8;
  localparam int unsigned SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   tick_mode    = 0;
  bit   exp_q[$];

  uart_tx_if #(.DBIT(DBIT)) bus ();

  uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Oversampling strobe: one clk every 4 in mode 0, random density in mode 1.
  initial begin
    int cnt;
    cnt        = 0;
    bus.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_mode == 0) begin
        cnt        = (cnt + 1) % 4;
        bus.s_tick = (cnt == 0);
      end else begin
        bus.s_tick = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Expected line level during each s_tick of a frame.
  function automatic void build_exp(input logic [DBIT-1:0] w);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
    for (int b = 0; b < DBIT; b++)
      for (int i = 0; i < 16; i++) exp_q.push_back(w[b]);
    if (PAR)
      for (int i = 0; i < 16; i++) exp_q.push_back(^w);
    for (int i = 0; i < SB_TICK; i++) exp_q.push_back(1'b1);
  endfunction

  // Sends one frame; entered and left at #1 after a rising edge.
  task automatic send_frame(input logic [DBIT-1:0] w, input bit hold,
                            input int interfere_at, input int abort_at);
    int   total, k, cyc;
    logic level, tick, pulse_on;
    build_exp(w);
    total        = exp_q.size();
    bus.tx_din   = w;
    bus.tx_start = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.tx !== 1'b0 || bus.tx_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL accept w=%h: tx=%b busy=%b, required tx=0 busy=1", w, bus.tx, bus.tx_busy);
    end
    if (!hold) bus.tx_start = 1'b0;
    bus.tx_din = DBIT'($urandom);
    level    = bus.tx;
    k        = 0;
    cyc      = 0;
    pulse_on = 1'b0;
    while (k < total) begin
      if (cyc >= 20000) begin
        tests_run++; tests_failed++;
        $display("FAIL timeout w=%h: %0d ticks seen, required %0d", w, k, total);
        break;
      end
      @(posedge clk);
      tick = bus.s_tick;
      #1;
      cyc++;
      if (pulse_on) begin
        bus.tx_start = hold;
        pulse_on     = 1'b0;
      end
      if (tick) begin
        tests_run++;
        if (level !== exp_q[k]) begin
          tests_failed++;
          $display("FAIL bit w=%h tick %0d: tx=%b, required %b", w, k, level, exp_q[k]);
        end
        k++;
        if (k == interfere_at) begin
          bus.tx_start = 1'b1;
          bus.tx_din   = {DBIT{1'b1}};
          pulse_on     = 1'b1;
        end
      end
      if (abort_at >= 0 && k == abort_at) begin
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done_tick !== 1'b0) begin
          tests_failed++;
          $display("FAIL abort w=%h: tx=%b busy=%b done=%b, required 1 0 0",
                   w, bus.tx, bus.tx_busy, bus.tx_done_tick);
        end
        repeat (3) @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.tx_start = 1'b0;
        return;
      end
      if (k == total) begin
        tests_run++;
        if (bus.tx_done_tick !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx !== 1'b1) begin
          tests_failed++;
          $display("FAIL end w=%h: done=%b busy=%b tx=%b, required 1 0 1",
                   w, bus.tx_done_tick, bus.tx_busy, bus.tx);
        end
      end else begin
        tests_run++;
        if (bus.tx_done_tick !== 1'b0 || bus.tx_busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL mid w=%h tick %0d: done=%b busy=%b, required 0 1",
                   w, k, bus.tx_done_tick, bus.tx_busy);
        end
      end
      level = bus.tx;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_din   = '0;
    #1;
    tests_run++;
    if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: tx=%b busy=%b done=%b, required 1 0 0",
               bus.tx, bus.tx_busy, bus.tx_done_tick);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done_tick !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle cycle %0d: tx=%b busy=%b done=%b, required 1 0 0",
                 i, bus.tx, bus.tx_busy, bus.tx_done_tick);
      end
    end
  endtask

  task automatic test_frame_55();
    tick_mode = 0;
    send_frame(DBIT'(8'h55), 1'b0, -1, -1);
  endtask

  task automatic test_ignore_busy();
    tick_mode = 0;
    send_frame(DBIT'(8'hA3), 1'b0, 50, -1);
    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus.tx_busy !== 1'b0 || bus.tx_done_tick !== 1'b0) begin
        tests_failed++;
        $display("FAIL ignore cycle %0d: busy=%b done=%b, required 0 0",
                 i, bus.tx_busy, bus.tx_done_tick);
        break;
      end
    end
  endtask

  task automatic test_back_to_back();
    tick_mode = 0;
    send_frame(DBIT'(8'h00), 1'b1, -1, -1);
    send_frame(DBIT'(8'hFF), 1'b0, -1, -1);
    test_idle(20);
  endtask

  task automatic test_reset_abort();
    tick_mode = 0;
    send_frame(DBIT'(8'h0F), 1'b0, -1, 70);
    test_idle(10);
    send_frame(DBIT'(8'h3C), 1'b0, -1, -1);
  endtask

  task automatic test_parity();
    tick_mode = 0;
    send_frame(DBIT'(8'h07), 1'b0, -1, -1);
    send_frame(DBIT'(8'h03), 1'b0, -1, -1);
  endtask

  task automatic test_random();
    tick_mode = 1;
    for (int i = 0; i < 8; i++) begin
      send_frame(DBIT'($urandom), 1'b0, int'($urandom_range(0, 150)), -1);
      test_idle(int'($urandom_range(0, 5)));
    end
    tick_mode = 0;
  endtask

  initial begin
    test_reset();
    test_idle(100);
    test_frame_55();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_parity();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
